// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one 64/64 divider between NREQ requesters.
// Divide-by-zero is answered without the divider; a hung divider is aborted by a timeout.
module divider_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TW      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*64-1:0]   dividend_in,
  input  logic [NREQ*64-1:0]   divisor_in,
  output logic [NREQ-1:0]      done,
  output logic                 error,
  output logic [127:0]         result,
  output logic                 busy,
  output logic [63:0]          div_dividend,
  output logic [63:0]          div_divisor,
  output logic                 div_start,
  input  logic [127:0]         div_result,
  input  logic                 div_result_valid
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam logic [IW-1:0] LastIdx = IW'(NREQ - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StDone} state_e;

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   grant_q;
  logic [TW-1:0]   cnt_q;
  logic [TW-1:0]   cnt_inc;
  logic [NREQ-1:0] done_q;
  logic            error_q;
  logic [127:0]    result_q;
  logic            start_q;
  logic [63:0]     dvd_q;
  logic [63:0]     dvs_q;

  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;
  logic [63:0]     gnt_dividend;
  logic [63:0]     gnt_divisor;

  // First requester at or after the pointer, wrapping at NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = IW'((int'(ptr_q) + k) % int'(NREQ));
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_dividend = '0;
    gnt_divisor  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (IW'(k) == gnt_idx) begin
        gnt_dividend = dividend_in[64*k +: 64];
        gnt_divisor  = divisor_in[64*k +: 64];
      end
    end
  end

  assign cnt_inc = cnt_q + TW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      done_q   <= '0;
      error_q  <= 1'b0;
      result_q <= '0;
      start_q  <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            grant_q <= gnt_idx;
            dvd_q   <= gnt_dividend;
            dvs_q   <= gnt_divisor;
            if (gnt_divisor == '0) begin
              result_q <= '1;
              error_q  <= 1'b1;
              done_q   <= NREQ'(1) << gnt_idx;
              state_q  <= StDone;
            end else begin
              // Start is a level held until the result is taken.
              start_q <= 1'b1;
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_inc;
          if (div_result_valid) begin
            result_q <= div_result;
            error_q  <= 1'b0;
            start_q  <= 1'b0;
            state_q  <= StDrain;
          end else if (cnt_inc == TW'(TIMEOUT)) begin
            result_q <= '1;
            error_q  <= 1'b1;
            start_q  <= 1'b0;
            state_q  <= StDrain;
          end
        end
        StDrain: begin
          done_q  <= NREQ'(1) << grant_q;
          state_q <= StDone;
        end
        StDone: begin
          ptr_q   <= (grant_q == LastIdx) ? '0 : grant_q + IW'(1);
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign done         = done_q;
  assign error        = error_q;
  assign result       = result_q;
  assign busy         = (state_q != StIdle);
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign div_start    = start_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Randomized bench for divider_arbiter against a transaction-timing reference model.
module tb_divider_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 100;
  localparam int unsigned TW      = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*64-1:0]   dividend_in;
  logic [NREQ*64-1:0]   divisor_in;
  logic [NREQ-1:0]      done;
  logic                 error;
  logic [127:0]         result;
  logic                 busy;
  logic [63:0]          div_dividend;
  logic [63:0]          div_divisor;
  logic                 div_start;
  logic [127:0]         div_result;
  logic                 div_result_valid;

  divider_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .dividend_in      (dividend_in),
    .divisor_in       (divisor_in),
    .done             (done),
    .error            (error),
    .result           (result),
    .busy             (busy),
    .div_dividend     (div_dividend),
    .div_divisor      (div_divisor),
    .div_start        (div_start),
    .div_result       (div_result),
    .div_result_valid (div_result_valid)
  );

  always #5 clk = ~clk;

  // Divider model: valid after m_lat cycles of start high, unless hung.
  int unsigned sc;
  int unsigned m_lat;
  bit          m_hang;
  bit          spurious;
  always @(posedge clk) sc <= div_start ? sc + 1 : 0;
  always_comb begin
    div_result_valid = spurious || (div_start && !m_hang && sc == m_lat);
    if (div_divisor == 64'd0) div_result = '0;
    else div_result = {div_dividend / div_divisor, div_dividend % div_divisor};
  end

  // Reference model state, indexed by edge count.
  int              cyc = 0;
  int              g_edge = -1, d_edge = -2, s_end = -2, free_edge = 0;
  int unsigned     m_ptr = 0, m_grant = 0;
  logic [127:0]    m_res = '0;
  logic            m_err = 1'b0;
  bit              hang_mode, rand_ops, exp_busy;
  int unsigned     force_lat;
  logic [NREQ-1:0] keep, exp_done;
  int unsigned     n_vec = 0, n_err = 0;
  int              start_cnt;
  int              done_log[$];
  int              done_edge_log[$];
  logic [127:0]    done_res_log[$];
  logic            done_err_log[$];
  int              exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int unsigned g, d;
    logic [63:0] a, b;
    bit fail;
    cyc++;
    if (rst) begin
      g_edge = -1; d_edge = -2; s_end = -2; free_edge = cyc + 1;
      m_ptr = 0; m_res = '0; m_err = 1'b0;
      return;
    end
    if (cyc >= free_edge && req != '0) begin
      g = m_ptr;
      while (!req[g]) g = (g + 1) % NREQ;
      a = dividend_in[64*g +: 64];
      b = divisor_in[64*g +: 64];
      m_grant = g;
      m_ptr = (g + 1) % NREQ;
      g_edge = cyc;
      if (b == 64'd0) begin
        m_res = '1; m_err = 1'b1; d_edge = cyc; s_end = cyc - 1;
      end else begin
        m_hang = hang_mode;
        m_lat = (force_lat != 0) ? force_lat : $urandom_range(1, TIMEOUT + 5);
        fail = m_hang || (m_lat > TIMEOUT);
        d = fail ? TIMEOUT : m_lat;
        m_err = fail;
        m_res = fail ? '1 : {a / b, a % b};
        d_edge = cyc + int'(d) + 2;
        s_end = cyc + int'(d);
      end
      free_edge = d_edge + 2;
    end
  endtask

  task automatic check_cycle();
    bit eb, es;
    eb = (cyc >= g_edge) && (cyc <= d_edge);
    es = (cyc >= g_edge) && (cyc <= s_end);
    exp_done = (cyc == d_edge) ? (NREQ'(1) << m_grant) : '0;
    exp_busy = eb;
    check("done", done, exp_done);
    check("busy", busy, eb);
    check("div_start", div_start, es);
    if (exp_done != '0 || !eb) begin
      check("result", result, m_res);
      check("error", error, m_err);
    end
    if (done != '0) begin
      for (int i = 0; i < NREQ; i++) if (done[i]) done_log.push_back(i);
      done_edge_log.push_back(cyc);
      done_res_log.push_back(result);
      done_err_log.push_back(error);
    end
    if (div_start) start_cnt++;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) if (exp_done[i] && !keep[i]) req[i] = 1'b0;
    spurious = !exp_busy && ($urandom_range(0, 5) == 0);
    if (rand_ops) begin
      for (int i = 0; i < NREQ; i++) begin
        dividend_in[64*i +: 64] = {$urandom, $urandom} >> $urandom_range(0, 40);
        divisor_in[64*i +: 64]  = ($urandom_range(0, 7) == 0) ? 64'd0 :
                                  ({$urandom, $urandom} >> $urandom_range(0, 62));
        if (!req[i] && $urandom_range(0, 5) == 0) req[i] = 1'b1;
      end
      // Requester withdrawing mid-operation must still get its done.
      if (exp_busy && $urandom_range(0, 40) == 0) req[m_grant] = 1'b0;
      hang_mode = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
    drive();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_logs();
    done_log.delete(); done_edge_log.delete(); done_res_log.delete(); done_err_log.delete();
  endtask

  task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b);
    dividend_in[64*i +: 64] = a;
    divisor_in[64*i +: 64]  = b;
  endtask

  task automatic run_dones(input string tag, input int n, input int budget);
    int k = 0;
    while (done_log.size() < n && k < budget) begin
      cycle();
      k++;
    end
    check({tag, "_done_count"}, done_log.size(), n);
  endtask

  task automatic check_order(input string tag);
    for (int k = 0; k < exp_q.size(); k++)
      if (k < done_log.size()) check($sformatf("%s_order%0d", tag, k), done_log[k], exp_q[k]);
  endtask

  task automatic one_shot(input string tag, input int idx, input logic [63:0] a,
                          input logic [63:0] b, input int unsigned lat, input bit hng,
                          input int exp_lat, input logic [127:0] exp_res, input bit exp_err,
                          input int exp_start);
    int t0;
    set_ops(idx, a, b);
    force_lat = lat;
    hang_mode = hng;
    start_cnt = 0;
    clear_logs();
    t0 = cyc;
    req[idx] = 1'b1;
    run_dones(tag, 1, 2 * TIMEOUT + 50);
    if (done_log.size() > 0) begin
      check({tag, "_who"}, done_log[0], idx);
      check({tag, "_latency"}, done_edge_log[0] - (t0 + 1), exp_lat);
      check({tag, "_result"}, done_res_log[0], exp_res);
      check({tag, "_error"}, done_err_log[0], exp_err);
    end
    idle(3);
    check({tag, "_start_cycles"}, start_cnt, exp_start);
    force_lat = 0;
    hang_mode = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; dividend_in = '0; divisor_in = '0; keep = '0;
    hang_mode = 1'b0; force_lat = 0; rand_ops = 1'b0;
    idle(3);
    rst = 1'b0;
    check("rst_div_dividend", div_dividend, 64'd0);
    check("rst_div_divisor", div_divisor, 64'd0);
    idle(2);

    // Contention: all four requesting, requester 0 comes straight back.
    for (int i = 0; i < NREQ; i++) set_ops(i, 64'(1000 * (i + 1) + 7), 64'(i + 3));
    clear_logs();
    keep = 4'b0001;
    req = 4'b1111;
    run_dones("contention", 5, 2000);
    req = '0; keep = '0;
    idle(3);
    exp_q = '{0, 1, 2, 3, 0};
    check_order("contention");

    one_shot("single", 0, 64'd8, 64'd2, 80, 1'b0, 82, {64'd4, 64'd0}, 1'b0, 81);

    // Reset during WAIT: no done, pending requests re-arbitrated from requester 0.
    set_ops(0, 64'd90, 64'd9);
    set_ops(3, 64'd50, 64'd7);
    force_lat = 80;
    clear_logs();
    req = 4'b1001;
    idle(20);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("rstwait_no_done", done_log.size(), 0);
    check("rstwait_div_dividend", div_dividend, 64'd0);
    force_lat = 0;
    run_dones("rstwait", 2, 1000);
    req = '0;
    idle(3);
    exp_q = '{0, 3};
    check_order("rstwait");

    // Fairness: 0 and 2 both re-request immediately.
    clear_logs();
    keep = 4'b0101;
    req = 4'b0101;
    run_dones("fair", 4, 2000);
    req = '0; keep = '0;
    idle(3);
    exp_q = '{0, 2, 0, 2};
    check_order("fair");

    one_shot("div0", 2, 64'd12345, 64'd0, 0, 1'b0, 0, '1, 1'b1, 0);
    one_shot("timeout", 1, 64'd77, 64'd5, 0, 1'b1, TIMEOUT + 2, '1, 1'b1, TIMEOUT + 1);
    one_shot("after_to", 1, 64'd16, 64'd2, 5, 1'b0, 7, {64'd8, 64'd0}, 1'b0, 6);
    one_shot("lat_eq_to", 3, 64'd100, 64'd10, TIMEOUT, 1'b0, TIMEOUT + 2,
             {64'd10, 64'd0}, 1'b0, TIMEOUT + 1);
    one_shot("lat_past_to", 0, 64'd100, 64'd10, TIMEOUT + 1, 1'b0, TIMEOUT + 2,
             '1, 1'b1, TIMEOUT + 1);
    one_shot("lat_one", 2, 64'd1001, 64'd10, 1, 1'b0, 3, {64'd100, 64'd1}, 1'b0, 2);

    rand_ops = 1'b1;
    idle(3000);
    rand_ops = 1'b0;
    req = '0;
    idle(TIMEOUT + 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
